// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-FF sync, 3-sample majority vote, configurable width/parity/stop bits.
// Word presented 1 clk after the last stop mid-sample; if the consumer still holds a word, the new one is dropped and overrun pulses.
module uart_rx_param #(
   parameter int DATA_W = 8,
   parameter int OS     = 16,
   parameter int DIV_W  = 16,
   parameter int STOP_W = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DIV_W-1:0]  baud_div,
   input  logic [1:0]        parity_mode,
   input  logic              serial_in,
   input  logic              rx_ready,
   output logic              rx_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun,
   output logic              rx_active
);

   localparam int TW = $clog2(OS);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [TW-1:0] T_S0  = TW'(OS / 2 - 1);
   localparam logic [TW-1:0] T_S1  = TW'(OS / 2);
   localparam logic [TW-1:0] T_S2  = TW'(OS / 2 + 1);
   localparam logic [TW-1:0] T_END = TW'(OS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t             state, state_nxt;
   logic               sin_m, sin_s, sin_d;
   logic [DIV_W-1:0]   div_cnt, div_r;
   logic [TW-1:0]      tick_cnt;
   logic [1:0]         mode_r;
   logic               s0, s1;
   logic [DATA_W-1:0]  shreg;
   logic [BW-1:0]      bit_cnt;
   logic               par_p, frm_p;
   logic               start_det, tick, vote, vote_vld, bit_end, par_on;
   logic               shift_en, par_chk, stop_chk, deliver, cnt_clr, cnt_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sin_m <= 1'b1;
         sin_s <= 1'b1;
         sin_d <= 1'b1;
      end else begin
         sin_m <= serial_in;
         sin_s <= sin_m;
         sin_d <= sin_s;
      end
   end

   assign start_det = (state == IDLE) && sin_d && !sin_s;
   assign tick      = (state != IDLE) && (div_cnt == div_r - DIV_W'(1));
   assign vote      = (s0 & s1) | (s0 & sin_s) | (s1 & sin_s);
   assign vote_vld  = tick && (tick_cnt == T_S2);
   assign bit_end   = tick && (tick_cnt == T_END);
   assign par_on    = (mode_r == 2'd1) || (mode_r == 2'd2);

   // Baud divisor and parity mode are frozen per frame at start detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         tick_cnt <= '0;
         div_r    <= '0;
         mode_r   <= '0;
         s0       <= 1'b0;
         s1       <= 1'b0;
      end else if (start_det) begin
         div_cnt  <= '0;
         tick_cnt <= '0;
         div_r    <= (baud_div == '0) ? DIV_W'(1) : baud_div;
         mode_r   <= parity_mode;
      end else if (state != IDLE) begin
         if (tick) begin
            div_cnt  <= '0;
            tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + TW'(1);
            if (tick_cnt == T_S0) s0 <= sin_s;
            if (tick_cnt == T_S1) s1 <= sin_s;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      par_chk   = 1'b0;
      stop_chk  = 1'b0;
      deliver   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: if (start_det) state_nxt = START;
         START: begin
            if (vote_vld && vote) state_nxt = IDLE;
            else if (bit_end) begin
               state_nxt = DATA;
               cnt_clr   = 1'b1;
            end
         end
         DATA: begin
            if (vote_vld) begin
               shift_en = 1'b1;
               cnt_inc  = 1'b1;
            end
            if (bit_end && bit_cnt == BW'(DATA_W)) begin
               cnt_clr   = 1'b1;
               state_nxt = par_on ? PARITY : STOP;
            end
         end
         PARITY: begin
            par_chk = vote_vld;
            if (bit_end) begin
               cnt_clr   = 1'b1;
               state_nxt = STOP;
            end
         end
         STOP: begin
            // Leave at the last stop mid-sample so the next start edge is caught early.
            if (vote_vld) begin
               stop_chk = 1'b1;
               if (bit_cnt == BW'(STOP_W - 1)) begin
                  deliver   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
         par_p   <= 1'b0;
         frm_p   <= 1'b0;
      end else begin
         if (start_det) begin
            par_p <= 1'b0;
            frm_p <= 1'b0;
         end
         if (cnt_clr)      bit_cnt <= '0;
         else if (cnt_inc) bit_cnt <= bit_cnt + BW'(1);
         if (shift_en) shreg <= {vote, shreg[DATA_W-1:1]};
         if (par_chk)  par_p <= vote != ((mode_r == 2'd1) ? ^shreg : ~^shreg);
         if (stop_chk && !vote) frm_p <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_valid   <= 1'b0;
         data_out   <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         rx_active  <= 1'b0;
      end else begin
         overrun   <= 1'b0;
         rx_active <= (state_nxt != IDLE);
         if (deliver) begin
            if (!rx_valid || rx_ready) begin
               rx_valid   <= 1'b1;
               data_out   <= shreg;
               parity_err <= par_p;
               frame_err  <= frm_p | ~vote;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: serial frames driven bit by bit, expected words queued and
// compared when the receiver hands them over; a second instance covers two stop bits.
module tb_uart_rx_param;

   logic        clk = 1'b0;
   logic        rst_n, serial_in, serial_in2, rx_ready, rx_ready2;
   logic [15:0] baud_div;
   logic [1:0]  parity_mode;
   logic        rx_valid, parity_err, frame_err, overrun, rx_active;
   logic        rx_valid2, parity_err2, frame_err2, overrun2, rx_active2;
   logic [7:0]  data_out, data_out2;

   int n_assert = 0;
   int n_fail   = 0;
   int vld_cnt  = 0;
   int ovr_cnt  = 0;
   int v0, o0;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   uart_rx_param #(.DATA_W(8), .OS(16), .DIV_W(16), .STOP_W(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
      .serial_in(serial_in), .rx_ready(rx_ready), .rx_valid(rx_valid), .data_out(data_out),
      .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .rx_active(rx_active));

   uart_rx_param #(.DATA_W(8), .OS(16), .DIV_W(16), .STOP_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
      .serial_in(serial_in2), .rx_ready(rx_ready2), .rx_valid(rx_valid2), .data_out(data_out2),
      .parity_err(parity_err2), .frame_err(frame_err2), .overrun(overrun2), .rx_active(rx_active2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rx_valid) vld_cnt++;
      if (overrun)  ovr_cnt++;
      if (rst_n && rx_valid && rx_ready) begin
         n_assert++;
         assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_word: observed %0h expected none", data_out);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("data_out", 32'(data_out), 32'(e.d));
            chk("parity_err", 32'(parity_err), 32'(e.pe));
            chk("frame_err", 32'(frame_err), 32'(e.fe));
         end
      end
   end

   // par < 0 means no parity bit; gbit selects a frame bit that gets a 4-clk inverted glitch.
   task automatic send(input bit which, input logic [7:0] d, input int par,
                       input logic st1, input logic st2, input int nstop, input int gbit);
      logic [11:0] bits;
      logic        v;
      int          n;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
      n = 9;
      if (par >= 0) begin
         bits[n] = par[0];
         n++;
      end
      bits[n] = st1;
      n++;
      if (nstop == 2) begin
         bits[n] = st2;
         n++;
      end
      for (int b = 0; b < n; b++) begin
         for (int c = 0; c < 64; c++) begin
            v = bits[b];
            if (b == gbit && c >= 34 && c < 38) v = ~v;
            if (which) serial_in2 = v;
            else       serial_in  = v;
            @(posedge clk);
         end
      end
      if (which) serial_in2 = 1'b1;
      else       serial_in  = 1'b1;
      repeat (64) @(posedge clk);
   endtask

   task automatic push(input logic [7:0] d, input logic pe, input logic fe);
      sb.push_back('{d: d, pe: pe, fe: fe});
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; serial_in = 1'b1; serial_in2 = 1'b1;
      rx_ready = 1'b1; rx_ready2 = 1'b0; parity_mode = 2'd0; baud_div = 16'd4;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_rx_active", 32'(rx_active), 32'd0);
      chk("rst_flags", 32'({parity_err, frame_err, overrun}), 32'd0);
      chk("rst_rx_valid2", 32'(rx_valid2), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (10) @(posedge clk);

      // Plain 8N1 frame, consumer always ready
      v0 = vld_cnt;
      push(8'hA5, 1'b0, 1'b0);
      send(0, 8'hA5, -1, 1'b1, 1'b1, 1, -1);
      drain();
      chk("t1_valid_cycles", 32'(vld_cnt - v0), 32'd1);

      // Parity: 0x55 has even weight, so even wants 0 and odd wants 1
      parity_mode = 2'd1;
      push(8'h55, 1'b1, 1'b0); send(0, 8'h55, 1, 1'b1, 1'b1, 1, -1);
      push(8'h55, 1'b0, 1'b0); send(0, 8'h55, 0, 1'b1, 1'b1, 1, -1);
      parity_mode = 2'd2;
      push(8'h55, 1'b0, 1'b0); send(0, 8'h55, 1, 1'b1, 1'b1, 1, -1);
      push(8'h55, 1'b1, 1'b0); send(0, 8'h55, 0, 1'b1, 1'b1, 1, -1);
      drain();

      // Framing error, single and double stop bits
      parity_mode = 2'd0;
      push(8'h3C, 1'b0, 1'b1);
      send(0, 8'h3C, -1, 1'b0, 1'b1, 1, -1);
      drain();
      send(1, 8'h5A, -1, 1'b1, 1'b1, 2, -1);
      chk("t3_valid2_a", 32'(rx_valid2), 32'd1);
      chk("t3_data2_a", 32'(data_out2), 32'h5A);
      chk("t3_ferr2_a", 32'(frame_err2), 32'd0);
      @(posedge clk) #1 rx_ready2 = 1'b1;
      @(posedge clk) #1 rx_ready2 = 1'b0;
      chk("t3_valid2_ack", 32'(rx_valid2), 32'd0);
      send(1, 8'hC3, -1, 1'b1, 1'b0, 2, -1);
      chk("t3_data2_b", 32'(data_out2), 32'hC3);
      chk("t3_ferr2_b", 32'(frame_err2), 32'd1);

      // Overrun: second word dropped while the first is held
      rx_ready = 1'b0;
      o0 = ovr_cnt;
      push(8'h11, 1'b0, 1'b0);
      send(0, 8'h11, -1, 1'b1, 1'b1, 1, -1);
      send(0, 8'h22, -1, 1'b1, 1'b1, 1, -1);
      chk("t4_valid_held", 32'(rx_valid), 32'd1);
      chk("t4_data_held", 32'(data_out), 32'h11);
      chk("t4_overrun_cycles", 32'(ovr_cnt - o0), 32'd1);
      @(posedge clk) #1 rx_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t4_valid_drop", 32'(rx_valid), 32'd0);
      drain();

      // Short glitch in idle is rejected as a false start
      v0 = vld_cnt;
      @(posedge clk) serial_in = 1'b0;
      repeat (3) @(posedge clk);
      serial_in = 1'b1;
      repeat (10) @(posedge clk);
      #1 chk("t5_active_on_glitch", 32'(rx_active), 32'd1);
      repeat (64) @(posedge clk);
      #1 chk("t5_active_cleared", 32'(rx_active), 32'd0);
      chk("t5_no_word", 32'(vld_cnt - v0), 32'd0);
      push(8'h6B, 1'b0, 1'b0);
      send(0, 8'h6B, -1, 1'b1, 1'b1, 1, 3);
      drain();

      // Reset in the middle of a frame
      @(posedge clk) serial_in = 1'b0;
      repeat (64) @(posedge clk);
      serial_in = 1'b1;
      repeat (160) @(posedge clk);
      #3 chk("t6_active_before", 32'(rx_active), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_active", 32'(rx_active), 32'd0);
      chk("t6_rst_data", 32'(data_out), 32'd0);
      chk("t6_rst_outputs", 32'({rx_valid, parity_err, frame_err, overrun}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (70) @(posedge clk);
      push(8'h81, 1'b0, 1'b0);
      send(0, 8'h81, -1, 1'b1, 1'b1, 1, -1);
      drain();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
